// File: rtl/bsg_manycore_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_mem_responder
// Brief    : Remote-memory responder. Runs decoded load/store requests on a
//            local 1-cycle SRAM and returns exactly one packet per request.
//            Optional macro BSG_MANYCORE_RESPONDER_LR_EN adds a load-reserve
//            tracker.
// Revision : 1.0
// ============================================================================
module bsg_manycore_mem_responder #(
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 10,
    parameter int mem_size_p        = 48,
    parameter int mem_addr_width_lp = $clog2(mem_size_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic                          in_v_i,
    output logic                          in_yumi_o,
    input  logic                          in_we_i,
    input  logic [addr_width_p-1:0]       in_addr_i,
    input  logic [data_width_p-1:0]       in_data_i,
    input  logic [data_width_p/8-1:0]     in_mask_i,
    input  logic [x_cord_width_p-1:0]     in_src_x_i,
    input  logic [y_cord_width_p-1:0]     in_src_y_i,

    output logic                          mem_v_o,
    output logic                          mem_w_o,
    output logic [mem_addr_width_lp-1:0]  mem_addr_o,
    output logic [data_width_p-1:0]       mem_data_o,
    output logic [data_width_p/8-1:0]     mem_mask_o,
    input  logic [data_width_p-1:0]       mem_data_i,

    output logic                          returning_v_o,
    input  logic                          returning_ready_i,
    output logic                          returning_load_o,
    output logic                          returning_err_o,
    output logic [data_width_p-1:0]       returning_data_o,
    output logic [x_cord_width_p-1:0]     returning_x_o,
    output logic [y_cord_width_p-1:0]     returning_y_o
`ifdef BSG_MANYCORE_RESPONDER_LR_EN
    ,
    input  logic                          reserve_v_i,
    input  logic [mem_addr_width_lp-1:0]  reserve_addr_i,
    output logic                          reservation_o
`endif
);

    localparam logic [mem_addr_width_lp:0] c_mem_size = mem_size_p[mem_addr_width_lp:0];

    typedef struct packed {
        logic                      load;
        logic                      err;
        logic [data_width_p-1:0]   data;
        logic [x_cord_width_p-1:0] x;
        logic [y_cord_width_p-1:0] y;
    } ret_s;

    // ---------------- range check ----------------
    logic                         w_hi_err;
    logic [mem_addr_width_lp-1:0] w_lo_idx;
    logic                         w_err;

    generate
        if (addr_width_p > mem_addr_width_lp) begin : g_hi_bits
            assign w_hi_err = |in_addr_i[addr_width_p-1:mem_addr_width_lp];
        end else begin : g_no_hi_bits
            assign w_hi_err = 1'b0;
        end
    endgenerate

    assign w_lo_idx = in_addr_i[mem_addr_width_lp-1:0];
    assign w_err    = w_hi_err | ({1'b0, w_lo_idx} >= c_mem_size);

    // ---------------- state ----------------
    logic                      s1_v_q;
    logic                      s1_we_q;
    logic                      s1_err_q;
    logic [x_cord_width_p-1:0] s1_x_q;
    logic [y_cord_width_p-1:0] s1_y_q;

    ret_s       fifo_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;

    logic       w_drain;
    logic [2:0] w_occ;
    ret_s       w_enq;
    ret_s       w_head;

    assign returning_v_o = (count_q != 2'd0);
    assign w_drain       = returning_v_o & returning_ready_i;

    // Occupancy counts every request that still owes a return, net of this
    // cycle's drain, so S1 always finds a free FIFO slot next cycle.
    assign w_occ     = {1'b0, count_q} + {2'b00, s1_v_q} - {2'b00, w_drain};
    assign in_yumi_o = in_v_i & ~reset_i & (w_occ < 3'd2);

    assign mem_v_o    = in_yumi_o & ~w_err;
    assign mem_w_o    = in_we_i;
    assign mem_addr_o = w_lo_idx;
    assign mem_data_o = in_data_i;
    assign mem_mask_o = in_mask_i;

    always_comb begin
        w_enq      = '0;
        w_enq.load = ~s1_we_q;
        w_enq.err  = s1_err_q;
        w_enq.data = (s1_we_q | s1_err_q) ? '0 : mem_data_i;
        w_enq.x    = s1_x_q;
        w_enq.y    = s1_y_q;
    end

    assign count_d = count_q + {1'b0, s1_v_q} - {1'b0, w_drain};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_v_q   <= 1'b0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            s1_v_q  <= in_yumi_o;
            count_q <= count_d;
            if (s1_v_q) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (w_drain) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (in_yumi_o) begin
            s1_we_q  <= in_we_i;
            s1_err_q <= w_err;
            s1_x_q   <= in_src_x_i;
            s1_y_q   <= in_src_y_i;
        end
        if (s1_v_q) begin
            fifo_q[wr_ptr_q] <= w_enq;
        end
    end

    assign w_head           = fifo_q[rd_ptr_q];
    assign returning_load_o = w_head.load;
    assign returning_err_o  = w_head.err;
    assign returning_data_o = w_head.data;
    assign returning_x_o    = w_head.x;
    assign returning_y_o    = w_head.y;

`ifdef BSG_MANYCORE_RESPONDER_LR_EN
    logic                         reservation_q;
    logic [mem_addr_width_lp-1:0] reserve_addr_q;
    logic                         w_resv_clear;

    assign w_resv_clear = in_yumi_o & in_we_i & ~w_err & (w_lo_idx == reserve_addr_q);

    // A new reservation takes priority over a clearing store in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            reservation_q <= 1'b0;
        end else if (reserve_v_i) begin
            reservation_q  <= 1'b1;
            reserve_addr_q <= reserve_addr_i;
        end else if (w_resv_clear) begin
            reservation_q <= 1'b0;
        end
    end

    assign reservation_o = reservation_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_manycore_mem_responder
// Brief    : Self-checking bench: directed table, corner sequences and random
//            traffic against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_bsg_manycore_mem_responder;

    localparam int c_x   = 4;
    localparam int c_y   = 4;
    localparam int c_d   = 32;
    localparam int c_a   = 10;
    localparam int c_m   = 48;
    localparam int c_maw = 6;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             in_v_i = 1'b0;
    logic             in_yumi_o;
    logic             in_we_i = 1'b0;
    logic [c_a-1:0]   in_addr_i = '0;
    logic [c_d-1:0]   in_data_i = '0;
    logic [3:0]       in_mask_i = '0;
    logic [c_x-1:0]   in_src_x_i = '0;
    logic [c_y-1:0]   in_src_y_i = '0;
    logic             mem_v_o;
    logic             mem_w_o;
    logic [c_maw-1:0] mem_addr_o;
    logic [c_d-1:0]   mem_data_o;
    logic [3:0]       mem_mask_o;
    logic [c_d-1:0]   mem_data_i;
    logic             returning_v_o;
    logic             returning_ready_i = 1'b0;
    logic             returning_load_o;
    logic             returning_err_o;
    logic [c_d-1:0]   returning_data_o;
    logic [c_x-1:0]   returning_x_o;
    logic [c_y-1:0]   returning_y_o;
`ifdef BSG_MANYCORE_RESPONDER_LR_EN
    logic             reserve_v_i = 1'b0;
    logic [c_maw-1:0] reserve_addr_i = '0;
    logic             reservation_o;
`endif

    bsg_manycore_mem_responder #(
        .x_cord_width_p (c_x),
        .y_cord_width_p (c_y),
        .data_width_p   (c_d),
        .addr_width_p   (c_a),
        .mem_size_p     (c_m)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .in_v_i            (in_v_i),
        .in_yumi_o         (in_yumi_o),
        .in_we_i           (in_we_i),
        .in_addr_i         (in_addr_i),
        .in_data_i         (in_data_i),
        .in_mask_i         (in_mask_i),
        .in_src_x_i        (in_src_x_i),
        .in_src_y_i        (in_src_y_i),
        .mem_v_o           (mem_v_o),
        .mem_w_o           (mem_w_o),
        .mem_addr_o        (mem_addr_o),
        .mem_data_o        (mem_data_o),
        .mem_mask_o        (mem_mask_o),
        .mem_data_i        (mem_data_i),
        .returning_v_o     (returning_v_o),
        .returning_ready_i (returning_ready_i),
        .returning_load_o  (returning_load_o),
        .returning_err_o   (returning_err_o),
        .returning_data_o  (returning_data_o),
        .returning_x_o     (returning_x_o),
        .returning_y_o     (returning_y_o)
`ifdef BSG_MANYCORE_RESPONDER_LR_EN
        ,
        .reserve_v_i       (reserve_v_i),
        .reserve_addr_i    (reserve_addr_i),
        .reservation_o     (reservation_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] pat(input int i);
        return (i == 16) ? 32'hDEAD_BEEF : (32'hCAFE_0000 | i);
    endfunction

    // ---------------- SRAM environment (1-cycle read latency) ----------------
    logic [31:0] sram [c_m];
    logic [31:0] rd_q = '0;
    logic        init_req = 1'b0;
    assign mem_data_i = rd_q;

    always @(posedge clk_i) begin
        if (init_req) begin
            for (int i = 0; i < c_m; i++) sram[i] <= pat(i);
        end else if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
            end else begin
                rd_q <= sram[mem_addr_o];
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic        ld;
        logic        er;
        logic [31:0] dat;
        logic [3:0]  x;
        logic [3:0]  y;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [c_m];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        smp_yumi, smp_rv, smp_ld, smp_er;
    logic [31:0] smp_dat;
    logic [3:0]  smp_x, smp_y;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // One clock: drive, sample mid-cycle against the model, then advance.
    task automatic cycle(input logic v, input logic we, input logic [c_a-1:0] addr,
                         input logic [31:0] data, input logic [3:0] mask,
                         input logic [3:0] x, input logic [3:0] y,
                         input logic rdy, input logic rst);
        logic erv, edrain, eerr, eyumi;
        exp_t e;
        in_v_i = v; in_we_i = we; in_addr_i = addr; in_data_i = data;
        in_mask_i = mask; in_src_x_i = x; in_src_y_i = y;
        returning_ready_i = rdy; reset_i = rst;
        #4;
        erv    = (q.size() > 0) && (q[0].due <= cyc);
        edrain = erv && rdy;
        eerr   = (int'(addr) >= c_m);
        eyumi  = v && !rst && ((q.size() - (edrain ? 1 : 0)) < 2);
        check("yumi", in_yumi_o, eyumi);
        check("mem_v", mem_v_o, eyumi && !eerr);
        if (eyumi && !eerr) begin
            check("mem_w", mem_w_o, we);
            check("mem_addr", mem_addr_o, addr[5:0]);
        end
        if (!rst) begin
            check("ret_v", returning_v_o, erv);
            if (erv) begin
                check("ret_load", returning_load_o, q[0].ld);
                check("ret_err", returning_err_o, q[0].er);
                check("ret_data", returning_data_o, q[0].dat);
                check("ret_x", returning_x_o, q[0].x);
                check("ret_y", returning_y_o, q[0].y);
            end
        end
        smp_yumi = in_yumi_o; smp_rv = returning_v_o; smp_ld = returning_load_o;
        smp_er = returning_err_o; smp_dat = returning_data_o;
        smp_x = returning_x_o; smp_y = returning_y_o;
        if (rst) begin
            q.delete();
        end else begin
            if (edrain) void'(q.pop_front());
            if (eyumi) begin
                e.due = cyc + 2; e.ld = !we; e.er = eerr; e.x = x; e.y = y;
                e.dat = (we || eerr) ? 32'h0 : ref_mem[addr];
                q.push_back(e);
                if (we && !eerr)
                    for (int b = 0; b < 4; b++)
                        if (mask[b]) ref_mem[addr][8*b +: 8] = data[8*b +: 8];
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, '0, '0, '0, '0, '0, rdy, 1'b0);
    endtask

    task automatic init_mem();
        for (int i = 0; i < c_m; i++) ref_mem[i] = pat(i);
        init_req = 1'b1;
        @(posedge clk_i);
        #1;
        init_req = 1'b0;
        cyc++;
    endtask

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [3:0]  x;
        logic [3:0]  y;
        logic        eld;
        logic        eer;
        logic [31:0] edat;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int n_acc, n_ret, first_rv, last_rv;

        tbl[0] = '{1'b0, 10'h010, 32'h0,          4'hF, 4'd2,  4'd3,  1'b1, 1'b0, 32'hDEAD_BEEF};
        tbl[1] = '{1'b1, 10'h005, 32'h1234_5678,  4'h3, 4'd1,  4'd1,  1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 10'h005, 32'h0,          4'hF, 4'd1,  4'd2,  1'b1, 1'b0, 32'hCAFE_5678};
        tbl[3] = '{1'b1, 10'h006, 32'hFFFF_FFFF,  4'h0, 4'd3,  4'd3,  1'b0, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 10'h006, 32'h0,          4'hF, 4'd0,  4'd0,  1'b1, 1'b0, 32'hCAFE_0006};
        tbl[5] = '{1'b0, 10'd52,  32'h0,          4'hF, 4'd5,  4'd6,  1'b1, 1'b1, 32'h0};
        tbl[6] = '{1'b1, 10'h3FF, 32'hAAAA_AAAA,  4'hF, 4'd7,  4'd7,  1'b0, 1'b1, 32'h0};
        tbl[7] = '{1'b0, 10'd47,  32'h0,          4'hF, 4'd15, 4'd15, 1'b1, 1'b0, 32'hCAFE_002F};
        tbl[8] = '{1'b0, 10'd48,  32'h0,          4'hF, 4'd0,  4'd1,  1'b1, 1'b1, 32'h0};

        @(posedge clk_i);
        #1;
        init_mem();
        // Reset with a valid request pending: nothing may be accepted.
        cycle(1'b1, 1'b0, 10'h1, '0, '0, '0, '0, 1'b1, 1'b1);
        idle(1'b1);
        check("reset_ret_v", smp_rv, 1'b0);

        // ---------------- directed table ----------------
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].mask,
                  tbl[i].x, tbl[i].y, 1'b1, 1'b0);
            check("tbl_yumi", smp_yumi, 1'b1);
            idle(1'b1);
            check("tbl_early", smp_rv, 1'b0);
            idle(1'b1);
            check("tbl_rv", smp_rv, 1'b1);
            check("tbl_load", smp_ld, tbl[i].eld);
            check("tbl_err", smp_er, tbl[i].eer);
            check("tbl_data", smp_dat, tbl[i].edat);
            check("tbl_xy", {smp_x, smp_y}, {tbl[i].x, tbl[i].y});
        end

        // ---------------- 8 back-to-back loads ----------------
        n_acc = 0; n_ret = 0; first_rv = -1; last_rv = -1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) cycle(1'b1, 1'b0, 10'(i), '0, 4'hF, 4'(i), 4'(7 - i), 1'b1, 1'b0);
            else idle(1'b1);
            if (i < 8 && smp_yumi) n_acc++;
            if (smp_rv) begin
                n_ret++;
                if (first_rv < 0) first_rv = i;
                last_rv = i;
            end
        end
        check("b2b_accepted", n_acc, 8);
        check("b2b_returns", n_ret, 8);
        check("b2b_contiguous", last_rv - first_rv + 1, 8);

        // ---------------- backpressure ----------------
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 10'(20 + i), '0, 4'hF, 4'd1, 4'(i), 1'b0, 1'b0);
            if (smp_yumi) n_acc++;
        end
        check("bp_accepted", n_acc, 2);
        idle(1'b0);
        check("bp_held", smp_rv, 1'b1);
        n_ret = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (smp_rv) n_ret++;
        end
        check("bp_returns", n_ret, 2);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 10'(30 + i), '0, 4'hF, 4'd2, 4'd2, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 10'h1, '0, 4'hF, 4'd0, 4'd0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 10'h1, '0, 4'hF, 4'd3, 4'd4, 1'b1, 1'b0);
        check("rst_ret_v", smp_rv, 1'b0);
        check("rst_yumi", smp_yumi, 1'b1);
        idle(1'b1);
        idle(1'b1);

`ifdef BSG_MANYCORE_RESPONDER_LR_EN
        reserve_v_i = 1'b1; reserve_addr_i = 6'h8;
        idle(1'b1);
        reserve_v_i = 1'b0;
        check("lr_set", reservation_o, 1'b1);
        cycle(1'b1, 1'b1, 10'h9, 32'h1, 4'hF, '0, '0, 1'b1, 1'b0);
        check("lr_other_addr", reservation_o, 1'b1);
        cycle(1'b1, 1'b1, 10'h8, 32'h2, 4'hF, '0, '0, 1'b1, 1'b0);
        check("lr_clear", reservation_o, 1'b0);
        reserve_v_i = 1'b1;
        cycle(1'b1, 1'b1, 10'h8, 32'h3, 4'hF, '0, '0, 1'b1, 1'b0);
        reserve_v_i = 1'b0;
        check("lr_set_wins", reservation_o, 1'b1);
        idle(1'b1);
        idle(1'b1);
        cycle(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        check("lr_reset", reservation_o, 1'b0);
`endif

        // ---------------- randomized traffic ----------------
        init_mem();
        for (int i = 0; i < 400; i++) begin
            logic [9:0] a;
            a = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(c_m, 1023))
                                            : 10'($urandom_range(0, c_m - 1));
            cycle($urandom_range(0, 9) < 7, 1'($urandom), a, $urandom,
                  4'($urandom), 4'($urandom), 4'($urandom),
                  $urandom_range(0, 9) < 7, 1'b0);
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
        check("rand_all_returned", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
